// File: rtl/plot_sink_if.sv
// Pixel-stream beat plus framebuffer write port for the plot sink.
// master = painter/framebuffer side, slave = plot_sink.
interface plot_sink_if;
    logic        plot;
    logic [8:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_ready;

    modport master (
        output plot, x, y, colour, mem_ready,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  plot, x, y, colour, mem_ready,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/plot_sink.sv
// Clips painter pixels, queues them and drains them into a stallable framebuffer port.
// Define PLOT_SINK_STATS_EN to build the saturating FIFO-full drop counter.
module plot_sink #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    plot_sink_if.slave       bus,
    input  logic             tick_in,
    output logic             frame_commit,
    output logic             overflow,
    output logic             busy,
    output logic [7:0]       drop_count
);

    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned ENTRY_W = ADDR_W + 3;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e              state_q, state_d;
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  head;
    logic                fifo_empty, fifo_full;
    logic                in_range, push, drop, pop;
    logic [ADDR_W-1:0]   pix_addr;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          wdata_q, wdata_d;
    logic                tick_q, tick_toggle;
    logic                commit_pending_q, commit_pending_d;
    logic                commit_fire;
    logic                frame_commit_q;
    logic                overflow_q;

    // ------------------------------------------------------------------
    // Clip and address
    // ------------------------------------------------------------------
    assign in_range = (32'(bus.x) < WIDTH) && (32'(bus.y) < HEIGHT);

    if (WIDTH == 160) begin : g_addr_shift
        // y*160 = y*128 + y*32
        assign pix_addr = ADDR_W'({bus.y, 7'b0}) + ADDR_W'({bus.y, 5'b0}) + ADDR_W'(bus.x);
    end else begin : g_addr_mul
        assign pix_addr = ADDR_W'((32'(bus.y) * WIDTH) + 32'(bus.x));
    end

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full is judged on the registered pointers, so a same-cycle pop never makes room.
    assign push = bus.plot && in_range && !fifo_full;
    assign drop = bus.plot && in_range && fifo_full;
    assign head = fifo_mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.colour, pix_addr};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (bus.mem_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            addr_d  = head[ADDR_W-1:0];
            wdata_d = head[ENTRY_W-1:ADDR_W];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.mem_we    = (state_q == StWrite);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Frame commit
    // ------------------------------------------------------------------
    assign tick_toggle = tick_in ^ tick_q;
    // Fires only once everything queued ahead of (and after) the toggle has been written.
    assign commit_fire = commit_pending_q && fifo_empty && (state_q == StIdle);

    always_comb begin
        commit_pending_d = commit_pending_q;
        if (commit_fire) begin
            commit_pending_d = 1'b0;
        end
        if (tick_toggle) begin
            commit_pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_q           <= 1'b0;
            commit_pending_q <= 1'b0;
            frame_commit_q   <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            tick_q           <= tick_in;
            commit_pending_q <= commit_pending_d;
            frame_commit_q   <= commit_fire;
            overflow_q       <= overflow_q | drop;
        end
    end

    assign frame_commit = frame_commit_q;
    assign overflow     = overflow_q;
    assign busy         = !fifo_empty || (state_q == StWrite);

    // ------------------------------------------------------------------
    // Optional drop statistics
    // ------------------------------------------------------------------
`ifdef PLOT_SINK_STATS_EN
    logic [7:0] drop_count_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            drop_count_q <= 8'd0;
        end else if (drop && (drop_count_q != 8'hff)) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink: reset, single write, clipping, commit ordering,
// coalescing, stall/overflow and reset mid-write.
module tb_plot_sink;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       tick_in;
    logic       frame_commit;
    logic       overflow;
    logic       busy;
    logic [7:0] drop_count;

    plot_sink_if bus ();

    plot_sink #(
        .WIDTH      (160),
        .HEIGHT     (120),
        .FIFO_DEPTH (8)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .bus          (bus),
        .tick_in      (tick_in),
        .frame_commit (frame_commit),
        .overflow     (overflow),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

`ifdef PLOT_SINK_STATS_EN
    localparam int ExpDrops = 3;
`else
    localparam int ExpDrops = 0;
`endif

    int          checks = 0;
    int          failures = 0;
    int          commit_cnt = 0;
    int          writes_at_commit = -1;
    logic [14:0] log_addr [$];
    logic [2:0]  log_data [$];

    // Completed writes and commit pulses, sampled on the active edge before it updates state.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            if (resetn === 1'b1) begin
                if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
                    log_addr.push_back(bus.mem_addr);
                    log_data.push_back(bus.mem_wdata);
                end
                if (frame_commit === 1'b1) begin
                    commit_cnt++;
                    writes_at_commit = log_addr.size();
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic put_pixel(input logic [8:0] px, input logic [6:0] py, input logic [2:0] pc);
        bus.plot   = 1'b1;
        bus.x      = px;
        bus.y      = py;
        bus.colour = pc;
        next_cycle();
        bus.plot   = 1'b0;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        commit_cnt       = 0;
        writes_at_commit = -1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        tick_in       = 1'b0;
        bus.plot      = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.colour    = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (bus.mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 15'd0) begin
            failures++; $display("FAIL reset_mem_addr got=%0d want=0", bus.mem_addr);
        end
        checks++;
        if (bus.mem_wdata !== 3'd0) begin
            failures++; $display("FAIL reset_mem_wdata got=%0d want=0", bus.mem_wdata);
        end
        checks++;
        if (frame_commit !== 1'b0) begin
            failures++; $display("FAIL reset_frame_commit got=%b want=0", frame_commit);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (drop_count !== 8'd0) begin
            failures++; $display("FAIL reset_drop_count got=%0d want=0", drop_count);
        end
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_pixel();
        clear_logs();
        bus.mem_ready = 1'b1;
        put_pixel(9'd5, 7'd2, 3'b010);
        @(negedge CLOCK_50);
        checks++;
        if (bus.mem_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_queued got=we%b/busy%b want=we0/busy1", bus.mem_we, busy);
        end
        next_cycle();
        @(negedge CLOCK_50);
        checks++;
        if (bus.mem_we !== 1'b1) begin
            failures++; $display("FAIL single_we got=%b want=1", bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 15'd325) begin
            failures++; $display("FAIL single_addr got=%0d want=325", bus.mem_addr);
        end
        checks++;
        if (bus.mem_wdata !== 3'b010) begin
            failures++; $display("FAIL single_wdata got=%b want=010", bus.mem_wdata);
        end
        next_cycle();
        @(negedge CLOCK_50);
        checks++;
        if (bus.mem_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done got=we%b/busy%b want=we0/busy0", bus.mem_we, busy);
        end
        checks++;
        if (log_addr.size() != 1) begin
            failures++; $display("FAIL single_write_count got=%0d want=1", log_addr.size());
        end
        next_cycle();
    endtask

    task automatic test_clipping();
        logic busy_seen;
        clear_logs();
        bus.mem_ready = 1'b1;
        busy_seen = 1'b0;
        put_pixel(9'd160, 7'd0, 3'd7);
        put_pixel(9'd0, 7'd120, 3'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            if (busy !== 1'b0) busy_seen = 1'b1;
            next_cycle();
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            failures++; $display("FAIL clip_busy got=1 want=0");
        end
        checks++;
        if (log_addr.size() != 0) begin
            failures++; $display("FAIL clip_writes got=%0d want=0", log_addr.size());
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL clip_overflow got=%b want=0", overflow);
        end
        checks++;
        if (drop_count !== 8'd0) begin
            failures++; $display("FAIL clip_drop_count got=%0d want=0", drop_count);
        end
        // Last in-range pixel: 119*160 + 159 = 19199
        put_pixel(9'd159, 7'd119, 3'd5);
        repeat (4) next_cycle();
        checks++;
        if (log_addr.size() != 1) begin
            failures++; $display("FAIL clip_corner_count got=%0d want=1", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 15'd19199 || log_data[0] !== 3'd5) begin
                failures++;
                $display("FAIL clip_corner got=%0d/%0d want=19199/5", log_addr[0], log_data[0]);
            end
        end
    endtask

    task automatic test_commit_order();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i % 2) == 1;
            put_pixel(9'(10 + i), 7'd0, 3'(i + 1));
        end
        tick_in = ~tick_in;
        for (int j = 0; j < 30; j++) begin
            bus.mem_ready = (j % 2) == 1;
            next_cycle();
        end
        bus.mem_ready = 1'b1;
        next_cycle();
        checks++;
        if (commit_cnt != 1) begin
            failures++; $display("FAIL commit_count got=%0d want=1", commit_cnt);
        end
        checks++;
        if (writes_at_commit != 4) begin
            failures++; $display("FAIL commit_after_writes got=%0d want=4", writes_at_commit);
        end
        checks++;
        if (log_addr.size() != 4) begin
            failures++; $display("FAIL commit_write_count got=%0d want=4", log_addr.size());
        end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 15'(10 + i) || log_data[i] !== 3'(i + 1)) begin
                failures++;
                $display("FAIL commit_write%0d got=%0d/%0d want=%0d/%0d",
                         i, log_addr[i], log_data[i], 10 + i, i + 1);
            end
        end
    endtask

    task automatic test_coalesce();
        clear_logs();
        bus.mem_ready = 1'b0;
        put_pixel(9'd20, 7'd1, 3'd3);
        put_pixel(9'd21, 7'd1, 3'd4);
        tick_in = ~tick_in;
        repeat (3) next_cycle();
        tick_in = ~tick_in;
        repeat (3) next_cycle();
        checks++;
        if (commit_cnt != 0) begin
            failures++; $display("FAIL coalesce_early got=%0d want=0", commit_cnt);
        end
        bus.mem_ready = 1'b1;
        repeat (20) next_cycle();
        checks++;
        if (commit_cnt != 1) begin
            failures++; $display("FAIL coalesce_count got=%0d want=1", commit_cnt);
        end
        checks++;
        if (writes_at_commit != 2) begin
            failures++; $display("FAIL coalesce_after_writes got=%0d want=2", writes_at_commit);
        end
    endtask

    task automatic test_stall_overflow();
        clear_logs();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            put_pixel(9'(i), 7'd1, 3'(i));
        end
        repeat (2) next_cycle();
        @(negedge CLOCK_50);
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL stall_overflow got=%b want=1", overflow);
        end
        checks++;
        if (drop_count !== 8'(ExpDrops)) begin
            failures++; $display("FAIL stall_drop_count got=%0d want=%0d", drop_count, ExpDrops);
        end
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd160) begin
            failures++;
            $display("FAIL stall_hold got=we%b/%0d want=we1/160", bus.mem_we, bus.mem_addr);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 40 && busy !== 1'b0; k++) next_cycle();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL stall_drain got=busy want=idle");
        end
        checks++;
        if (log_addr.size() != 9) begin
            failures++; $display("FAIL stall_write_count got=%0d want=9", log_addr.size());
        end
        for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 15'(160 + i) || log_data[i] !== 3'(i)) begin
                failures++;
                $display("FAIL stall_write%0d got=%0d/%0d want=%0d/%0d",
                         i, log_addr[i], log_data[i], 160 + i, i % 8);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        clear_logs();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put_pixel(9'(30 + i), 7'd2, 3'(i));
        end
        @(negedge CLOCK_50);
        checks++;
        if (bus.mem_we !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got=we%b/busy%b want=we1/busy1", bus.mem_we, busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd0 || bus.mem_wdata !== 3'd0) begin
            failures++;
            $display("FAIL midrst_mem got=we%b/%0d/%0d want=we0/0/0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0 || frame_commit !== 1'b0 || drop_count !== 8'd0)
        begin
            failures++;
            $display("FAIL midrst_status got=busy%b/ovf%b/fc%b/drop%0d want=0/0/0/0",
                     busy, overflow, frame_commit, drop_count);
        end
        clear_logs();
        next_cycle();
        resetn        = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (6) next_cycle();
        checks++;
        if (log_addr.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet got=writes%0d/busy%b want=0/0", log_addr.size(), busy);
        end
        // 3*160 + 3 = 483
        put_pixel(9'd3, 7'd3, 3'd6);
        repeat (4) next_cycle();
        checks++;
        if (log_addr.size() != 1) begin
            failures++; $display("FAIL midrst_new_count got=%0d want=1", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 15'd483 || log_data[0] !== 3'd6) begin
                failures++;
                $display("FAIL midrst_new got=%0d/%0d want=483/6", log_addr[0], log_data[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_clipping();
        test_commit_order();
        test_coalesce();
        test_stall_overflow();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
